// File: rtl/column_blitter.sv
// Column blitter: drains a double-buffered line RAM column by column into a
// ready/valid pixel stream with frame-start/end markers and an overflow flag.
module column_blitter #(
    parameter int HEIGHT    = 240,
    parameter int WIDTH     = 320,
    parameter int RAM_ASIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 line_done,
    output logic [RAM_ASIZE:0]   ram_raddr,
    input  logic [15:0]          ram_read_data,
    output logic                 buf_free,
    output logic [15:0]          px_data,
    output logic                 px_valid,
    input  logic                 px_ready,
    output logic                 px_first,
    output logic                 px_last,
    output logic                 frame_done,
    output logic                 overflow
);

    localparam int AW = RAM_ASIZE + 1;
    localparam int IW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);
    localparam logic [IW-1:0] IDX_LAST = IW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [AW-1:0] BASE_B   = AW'(HEIGHT);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t          r_state, w_state_next;
    logic [1:0]      r_fill_cnt, w_fill_next;
    logic            r_overflow, w_ovf_set;
    logic [AW-1:0]   r_rd_base;
    logic [IW-1:0]   r_rd_idx;
    logic            r_inflight;
    logic [15:0]     r_fifo_mem [2];
    logic            r_wr_ptr, r_rd_ptr;
    logic [1:0]      r_fifo_cnt;
    logic [IW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic            r_frame_done;

    logic            w_pop, w_push, w_rd_en, w_drain;
    logic [1:0]      w_occ;

    // Occupancy counts the slot freed by this cycle's pop so a steady
    // one-pixel-per-cycle flow is possible without ever exceeding two entries.
    always_comb begin
        w_pop   = px_valid && px_ready;
        w_push  = r_inflight;
        w_occ   = r_fifo_cnt - 2'(w_pop) + 2'(r_inflight);
        w_rd_en = (r_state == S_STREAM) && (w_occ < 2'd2);
        w_drain = w_rd_en && (r_rd_idx == IDX_LAST);
    end

    always_comb begin
        w_fill_next  = r_fill_cnt;
        w_ovf_set    = 1'b0;
        w_state_next = r_state;
        case ({line_done, w_drain})
            2'b10: begin
                if (r_fill_cnt == 2'd2) w_ovf_set   = 1'b1;
                else                    w_fill_next = r_fill_cnt + 2'd1;
            end
            2'b01:   w_fill_next = r_fill_cnt - 2'd1;
            default: w_fill_next = r_fill_cnt;
        endcase
        case (r_state)
            S_IDLE:   if (r_fill_cnt != 2'd0) w_state_next = S_STREAM;
            S_STREAM: if (w_drain && w_fill_next == 2'd0) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_fill_cnt <= 2'd0;
            r_overflow <= 1'b0;
            r_rd_base  <= '0;
            r_rd_idx   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fill_cnt <= w_fill_next;
            r_inflight <= w_rd_en;
            if (w_ovf_set) r_overflow <= 1'b1;
            if (w_drain) begin
                r_rd_idx  <= '0;
                r_rd_base <= (r_rd_base == '0) ? BASE_B : '0;
            end else if (w_rd_en) begin
                r_rd_idx  <= r_rd_idx + 1'b1;
            end
        end
    end

    // Two-entry skid FIFO holding RAM data returned one cycle after each read.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                r_fifo_mem[gi] <= '0;
            else if (w_push && r_wr_ptr == 1'(gi))     r_fifo_mem[gi] <= ram_read_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_fifo_cnt   <= 2'd0;
            r_row        <= '0;
            r_col        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_fifo_cnt   <= r_fifo_cnt + 2'(w_push) - 2'(w_pop);
            r_frame_done <= w_pop && px_last;
            if (w_pop) begin
                if (r_row == IDX_LAST) begin
                    r_row <= '0;
                    r_col <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end
        end
    end

    // Frame markers follow the head beat's position, tracked by the output counters.
    always_comb begin
        ram_raddr  = r_rd_base + AW'(r_rd_idx);
        buf_free   = (r_fill_cnt < 2'd2);
        px_valid   = (r_fifo_cnt != 2'd0);
        px_data    = r_fifo_mem[r_rd_ptr];
        px_first   = px_valid && (r_row == '0) && (r_col == '0);
        px_last    = px_valid && (r_row == IDX_LAST) && (r_col == COL_LAST);
        frame_done = r_frame_done;
        overflow   = r_overflow;
    end

endmodule

// File: tb/tb_column_blitter.sv
// Directed bench for column_blitter: latency, back-to-back columns, back-pressure,
// overflow, full frame markers and mid-column reset.
module tb_column_blitter;

    localparam int HEIGHT = 240;
    localparam int WIDTH  = 320;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line_done = 1'b0;
    logic [8:0]  ram_raddr;
    logic [15:0] ram_read_data = '0;
    logic        buf_free;
    logic [15:0] px_data;
    logic        px_valid;
    logic        px_ready = 1'b0;
    logic        px_first, px_last, frame_done, overflow;

    column_blitter #(.HEIGHT(HEIGHT), .WIDTH(WIDTH), .RAM_ASIZE(8)) dut (
        .clk(clk), .rst_n(rst_n), .line_done(line_done), .ram_raddr(ram_raddr),
        .ram_read_data(ram_read_data), .buf_free(buf_free), .px_data(px_data),
        .px_valid(px_valid), .px_ready(px_ready), .px_first(px_first),
        .px_last(px_last), .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:511];
    always @(posedge clk) ram_read_data <= mem[ram_raddr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] q_data[$];
    bit          q_first[$];
    bit          q_last[$];
    int          q_cyc[$];
    int          stall_err = 0, fd_cnt = 0, fd_cyc = 0, bf_low = 0;
    bit          stalled = 1'b0;
    logic [15:0] held = '0;

    always @(negedge clk) begin
        if (px_valid && px_ready) begin
            q_data.push_back(px_data);
            q_first.push_back(px_first);
            q_last.push_back(px_last);
            q_cyc.push_back(cyc);
        end
        if (stalled && px_valid && px_data !== held) stall_err++;
        stalled = px_valid && !px_ready;
        held    = px_data;
        if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
        if (!buf_free) bf_low++;
    end

    int checks = 0, passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        q_data.delete(); q_first.delete(); q_last.delete(); q_cyc.delete();
        stall_err = 0; fd_cnt = 0; bf_low = 0;
    endtask

    task automatic do_reset();
        line_done = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        clear_mon();
    endtask

    task automatic load_mem(input bit ab);
        for (int i = 0; i < 2*HEIGHT; i++)
            mem[i] = ab ? ((i < HEIGHT) ? 16'hA000 + 16'(i) : 16'hB000 + 16'(i - HEIGHT))
                        : 16'h1000 + 16'(i % HEIGHT);
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int i = 0;
        while (q_data.size() < n && i < budget) begin tick(); i++; end
        check(tag, q_data.size(), n);
    endtask

    // Writer model: pulses line_done whenever a half is free, up to ncols columns.
    task automatic run_writer(input int ncols, input int stop_beats, input int budget);
        int cols = 0;
        int i = 0;
        while (q_data.size() < stop_beats && i < budget) begin
            line_done = buf_free && (cols < ncols);
            if (line_done) cols++;
            tick(); i++;
        end
        line_done = 1'b0;
    endtask

    // mode 0: every column 0x1000+row; mode 1: even columns 0xA000+row, odd 0xB000+row
    function automatic int data_errs(input int n, input bit mode);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            logic [15:0] exp;
            if (!mode) exp = 16'h1000 + 16'(i % HEIGHT);
            else exp = (((i / HEIGHT) % 2) ? 16'hB000 : 16'hA000) + 16'(i % HEIGHT);
            if (q_data[i] !== exp) e++;
        end
        return e;
    endfunction

    function automatic int gap_errs(input int n);
        int e = 0;
        for (int i = 1; i < n; i++) if (q_cyc[i] != q_cyc[0] + i) e++;
        return e;
    endfunction

    function automatic int count_bits(input bit which);
        int c = 0;
        for (int i = 0; i < q_data.size(); i++) c += which ? int'(q_last[i]) : int'(q_first[i]);
        return c;
    endfunction

    initial begin
        load_mem(1'b0);
        rst_n = 1'b0;
        tick();
        check("rst_px_valid",   px_valid,   0);
        check("rst_px_first",   px_first,   0);
        check("rst_px_last",    px_last,    0);
        check("rst_frame_done", frame_done, 0);
        check("rst_buf_free",   buf_free,   1);
        check("rst_ram_raddr",  ram_raddr,  0);
        check("rst_px_data",    px_data,    0);
        check("rst_overflow",   overflow,   0);
        do_reset();

        // Single column: latency and contiguous stream
        px_ready = 1'b1;
        line_done = 1'b1; tick(); line_done = 1'b0;
        tick(); tick();
        check("t1_valid_k2", px_valid, 0);
        tick();
        check("t1_valid_k3", px_valid, 1);
        check("t1_first_k3", px_first, 1);
        check("t1_data_k3",  px_data,  16'h1000);
        wait_beats(HEIGHT, 400, "t1_beats");
        check("t1_data",    data_errs(HEIGHT, 1'b0), 0);
        check("t1_gaps",    gap_errs(HEIGHT), 0);
        check("t1_nfirst",  count_bits(1'b0), 1);
        check("t1_nlast",   count_bits(1'b1), 0);
        check("t1_buffree", bf_low, 0);
        tick(); tick();
        check("t1_idle_valid", px_valid, 0);
        check("t1_raddr_b",    ram_raddr, HEIGHT);

        // Back-to-back columns
        do_reset();
        load_mem(1'b1);
        line_done = 1'b1; tick(); tick(); line_done = 1'b0;
        check("t2_buffree_full", buf_free, 0);
        repeat (239) tick();
        check("t2_buffree_k240", buf_free, 0);
        tick();
        check("t2_buffree_k241", buf_free, 1);
        wait_beats(2*HEIGHT, 700, "t2_beats");
        check("t2_data", data_errs(2*HEIGHT, 1'b1), 0);
        check("t2_gaps", gap_errs(2*HEIGHT), 0);
        check("t2_nfirst", count_bits(1'b0), 1);
        tick(); tick();
        check("t2_idle_valid", px_valid, 0);
        check("t2_raddr_a", ram_raddr, 0);

        // Random back-pressure
        do_reset();
        load_mem(1'b0);
        line_done = 1'b1; tick(); line_done = 1'b0;
        for (int i = 0; i < 3000 && q_data.size() < HEIGHT; i++) begin
            px_ready = 1'($urandom_range(0, 1));
            tick();
        end
        px_ready = 1'b1;
        check("t3_beats", q_data.size(), HEIGHT);
        check("t3_data",  data_errs(HEIGHT, 1'b0), 0);
        check("t3_stall", stall_err, 0);

        // Overflow
        do_reset();
        px_ready = 1'b0;
        line_done = 1'b1; tick(); tick();
        check("t4_ovf_2", overflow, 0);
        check("t4_buffree_2", buf_free, 0);
        tick(); line_done = 1'b0;
        check("t4_ovf_3", overflow, 1);
        repeat (20) tick();
        check("t4_ovf_sticky", overflow, 1);
        check("t4_valid_stalled", px_valid, 1);
        rst_n = 1'b0; #1;
        check("t4_ovf_rst", overflow, 0);
        tick();
        px_ready = 1'b1;

        // Full frame
        do_reset();
        load_mem(1'b1);
        run_writer(WIDTH, WIDTH*HEIGHT, 80000);
        repeat (5) tick();
        check("t5_beats",  q_data.size(), WIDTH*HEIGHT);
        check("t5_data",   data_errs(WIDTH*HEIGHT, 1'b1), 0);
        check("t5_nfirst", count_bits(1'b0), 1);
        check("t5_nlast",  count_bits(1'b1), 1);
        check("t5_last_pos", q_last[q_last.size()-1], 1);
        check("t5_fd_cnt", fd_cnt, 1);
        check("t5_fd_cyc", fd_cyc, q_cyc[q_cyc.size()-1] + 1);
        run_writer(1, WIDTH*HEIGHT + 1, 400);
        check("t5_next_first", q_first[q_first.size()-1], 1);

        // Reset at pixel 100 of column 5
        do_reset();
        run_writer(WIDTH, 5*HEIGHT + 100, 3000);
        check("t6_head", px_data, 16'hB000 + 16'd100);
        rst_n = 1'b0; #1;
        check("t6_px_valid",   px_valid,   0);
        check("t6_px_first",   px_first,   0);
        check("t6_px_last",    px_last,    0);
        check("t6_frame_done", frame_done, 0);
        check("t6_buf_free",   buf_free,   1);
        check("t6_ram_raddr",  ram_raddr,  0);
        check("t6_px_data",    px_data,    0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        clear_mon();
        line_done = 1'b1; tick(); line_done = 1'b0;
        wait_beats(HEIGHT, 400, "t6_beats");
        check("t6_first_data", q_data[0], 16'hA000);
        check("t6_data", data_errs(HEIGHT, 1'b1), 0);
        check("t6_first_flag", q_first[0], 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/column_blitter.md
COLUMN_BLITTER -- requirements
Module: column_blitter

Interface
REQ-001 Parameter HEIGHT, default 240: pixels per column (line RAM half size).
REQ-002 Parameter WIDTH, default 320: columns per frame.
REQ-003 Parameter RAM_ASIZE, default 8: line RAM read address MSB index (address width RAM_ASIZE+1).
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-006 line_done  input  1  one-cycle pulse from the line writer: one column has been fully written to line RAM.
REQ-007 ram_raddr  output  RAM_ASIZE+1  line RAM read address.
REQ-008 ram_read_data  input  16  line RAM read data, RGB565, valid one cycle after ram_raddr.
REQ-009 buf_free  output  1  high when the line writer may start another column.
REQ-010 px_data  output  16  pixel to the LCD write stage.
REQ-011 px_valid  output  1  px_data valid.
REQ-012 px_ready  input  1  LCD stage accepts the beat when px_valid and px_ready are both high.
REQ-013 px_first  output  1  qualifies px_data: pixel 0 of column 0 of the frame.
REQ-014 px_last  output  1  qualifies px_data: pixel HEIGHT-1 of column WIDTH-1.
REQ-015 frame_done  output  1  one-cycle pulse after the px_last beat is accepted.
REQ-016 overflow  output  1  sticky error flag.

Function
REQ-017 Line RAM is double-buffered: half A at base 0, half B at base HEIGHT; the writer fills A first after reset, then alternates.
REQ-018 fill_cnt (0..2) counts written-but-not-drained halves: +1 on line_done, -1 on the cycle the last pixel of a column is read from RAM; both in one cycle leave it unchanged.
REQ-019 buf_free = (fill_cnt < 2), registered-state based, no combinational path from line_done.
REQ-020 line_done while fill_cnt == 2 (with no simultaneous drain) leaves fill_cnt unchanged and sets overflow until reset.
REQ-021 States: IDLE, STREAM. IDLE -> STREAM when fill_cnt > 0; STREAM -> IDLE after the last column pixel is read and fill_cnt becomes 0; otherwise STREAM continues directly into the next half with no idle cycle.
REQ-022 ram_raddr = rd_base + rd_idx; rd_idx runs 0..HEIGHT-1; rd_base toggles 0 <-> HEIGHT after each column's last read.
REQ-023 Returned data enters a 2-entry output FIFO; a read is issued only when FIFO occupancy plus in-flight reads < 2, so no datum is ever dropped.
REQ-024 px_valid = FIFO non-empty; px_data/px_first/px_last come from the FIFO head and are held stable while px_valid && !px_ready.
REQ-025 Throughput: one pixel per cycle while px_ready stays high.
REQ-026 Latency: line_done sampled high at edge k with fill_cnt 0 and FIFO empty -> px_valid high after edge k+3.
REQ-027 Output column counter 0..WIDTH-1 and row counter 0..HEIGHT-1 advance on accepted beats only; both wrap to 0 after px_last is accepted.
REQ-028 frame_done pulses for exactly one cycle, the cycle after the px_last beat is accepted.
REQ-029 A px_ready deassertion stalls reads; no address skipped or repeated.

Reset
REQ-030 While rst_n low: state IDLE, fill_cnt 0, rd_base 0, rd_idx 0, FIFO empty, counters 0, overflow 0.
REQ-031 Reset outputs: px_valid 0, px_first 0, px_last 0, frame_done 0, buf_free 1, ram_raddr 0, px_data 0.
REQ-032 Reset mid-column discards in-flight data; the line writer shares rst_n, so both restart at half A.

Verification
REQ-033 Single column: preload half A with value 0x1000+i at address i, pulse line_done, px_ready high -> 240 beats 0x1000..0x10EF on consecutive cycles, first valid at k+3, px_first on beat 0, buf_free stays 1.
REQ-034 Back-to-back: fill both halves (A 0xA000+i, B 0xB000+i), two line_done pulses -> buf_free 0 after second; 480 contiguous beats A then B, no bubble; buf_free returns 1 when A's last read is issued.
REQ-035 Back-pressure: px_ready random 50% -> beat sequence identical to REQ-033 data, px_data stable during every stall.
REQ-036 Overflow: three line_done pulses with px_ready 0 -> fill_cnt 2, overflow 1 after third pulse, stays 1 until rst_n.
REQ-037 Full frame: 320 columns -> exactly 76800 beats, px_last only on beat 76799, frame_done single pulse next cycle, next beat carries px_first.
REQ-038 Reset at pixel 100 of column 5 -> all outputs at REQ-031 values immediately; next line_done streams from address 0.
